// File: rtl/imem_sync.sv
// imem_sync -- clocked instruction memory for the fetch stage.
//
// A request that is accepted at a rising edge has its response registered at
// that same edge, so resp_valid rises one cycle after the request cycle. There
// is a single response register, so at most one response is outstanding.
// A byte-enabled load port writes program contents. A flush input drops the
// pending response. Misaligned and out-of-range fetches return NOP_WORD and
// raise a fault flag.
//
// Build option: define IMEM_PARITY_EN to store an even-parity bit with each
// word. This adds the resp_parity_err output and the ld_parity_flip input.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready fetch request handshake, req_addr = byte address
//   resp_valid/ready    response handshake; resp_data, resp_pc, fault flags
//   flush               discard pending response, block accepts this cycle
//   ld_en/addr/data/be  program-load write port (word index, byte enables)
//   ld_parity_flip      (IMEM_PARITY_EN) invert stored parity on a load
//   resp_parity_err     (IMEM_PARITY_EN) stored parity mismatches read word
//
// Handshake semantics: a transfer happens on a rising edge where both valid
// and ready are high. The producer keeps valid and its payload stable until
// that transfer. Ready may depend combinationally on the other side's state,
// but never on the valid of the same channel.
module imem_sync #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  input  logic [ADDR_W-1:0]              req_addr,
  output logic                           req_ready,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [31:0]                    resp_data,
  output logic [ADDR_W-1:0]              resp_pc,
  output logic                           resp_fault_misalign,
  output logic                           resp_fault_range,
  input  logic                           flush,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data,
  input  logic [3:0]                     ld_be
`ifdef IMEM_PARITY_EN
  ,
  input  logic                           ld_parity_flip,
  output logic                           resp_parity_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Contents start as NOP_WORD. Reset never touches the array.
  logic [31:0] mem [DEPTH_WORDS] = '{default: NOP_WORD};

  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_word;
  logic             f_misalign;
  logic             f_range;
  logic             accept;
  logic             ld_write;
  logic [31:0]      ld_merged;

  assign rd_idx     = req_addr[IDX_W+1:2];
  assign rd_word    = mem[rd_idx];
  assign f_misalign = |req_addr[1:0];

  // DEPTH_WORDS is a power of two. So "word index >= DEPTH_WORDS" is the same
  // as "any address bit above the word-index field is set".
  if (ADDR_W > IDX_W + 2) begin : g_range
    assign f_range = |req_addr[ADDR_W-1:IDX_W+2];
  end else begin : g_no_range
    assign f_range = 1'b0;
  end

  assign req_ready = !rst && !flush && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;
  assign ld_write  = ld_en && (|ld_be);

  // Merge the enabled load bytes into the current word. Parity needs the final
  // word, and a full-word write keeps the array as a single write port.
  always_comb begin
    ld_merged = mem[ld_addr];
    for (int i = 0; i < 4; i++) begin
      if (ld_be[i]) ld_merged[8*i +: 8] = ld_data[8*i +: 8];
    end
  end

  // The response register samples rd_word before this edge's write lands.
  // That gives read-before-write behaviour on a same-word collision.
  always_ff @(posedge clk) begin
    if (ld_write) mem[ld_addr] <= ld_merged;
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH_WORDS] = '{default: ^NOP_WORD};
  logic rd_par_err;

  assign rd_par_err = (^rd_word) != par_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (ld_write) par_mem[ld_addr] <= (^ld_merged) ^ ld_parity_flip;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid          <= 1'b0;
      resp_data           <= NOP_WORD;
      resp_pc             <= '0;
      resp_fault_misalign <= 1'b0;
      resp_fault_range    <= 1'b0;
`ifdef IMEM_PARITY_EN
      resp_parity_err     <= 1'b0;
`endif
    end else if (flush) begin
      // Data and pc keep their last values. Only the status is cleared.
      resp_valid          <= 1'b0;
      resp_fault_misalign <= 1'b0;
      resp_fault_range    <= 1'b0;
`ifdef IMEM_PARITY_EN
      resp_parity_err     <= 1'b0;
`endif
    end else if (accept) begin
      resp_valid          <= 1'b1;
      resp_pc             <= req_addr;
      resp_data           <= (f_misalign || f_range) ? NOP_WORD : rd_word;
      resp_fault_misalign <= f_misalign;
      resp_fault_range    <= f_range;
`ifdef IMEM_PARITY_EN
      resp_parity_err     <= rd_par_err && !(f_misalign || f_range);
`endif
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// Bench for imem_sync. The driver runs directed cases and then random traffic.
// A reference model keeps the expected memory image and pushes each expected
// response onto a queue when a request is accepted. A monitor on the falling
// edge compares the DUT outputs with the queue front, or with the last held
// response when nothing is pending.
module tb_imem_sync;

  localparam int          DEPTH = 256;
  localparam int          AW    = 32;
  localparam int          IW    = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        mis;
    logic        rng;
    logic        perr;
  } resp_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req_valid, req_ready, resp_valid, resp_ready;
  logic [AW-1:0] req_addr, resp_pc;
  logic [31:0]   resp_data, ld_data;
  logic          resp_fault_misalign, resp_fault_range, flush, ld_en;
  logic [IW-1:0] ld_addr;
  logic [3:0]    ld_be;
  logic          ld_parity_flip;
  logic          resp_parity_err;

  imem_sync #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_pc(resp_pc),
    .resp_fault_misalign(resp_fault_misalign), .resp_fault_range(resp_fault_range),
    .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be)
`ifdef IMEM_PARITY_EN
    , .ld_parity_flip(ld_parity_flip), .resp_parity_err(resp_parity_err)
`endif
  );

`ifndef IMEM_PARITY_EN
  assign resp_parity_err = 1'b0;
`endif

  // scoreboard state
  int          vectors = 0;
  int          miscompares = 0;
  resp_t       exp_q[$];
  resp_t       last_r;
  logic [31:0] mdl_mem [DEPTH];
  logic        mdl_bad [DEPTH];
  logic        mon_en = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mdl_mem[i] = NOP;
      mdl_bad[i] = 1'b0;
    end
  end

  // reference model: acts on the inputs at each rising edge
  always @(posedge clk) begin
    logic        rdy;
    logic [31:0] widx;
    resp_t       r;
    rdy = !rst && !flush && ((exp_q.size() == 0) || resp_ready);
    if (rst) begin
      exp_q.delete();
      last_r = '{data: NOP, pc: 32'd0, mis: 1'b0, rng: 1'b0, perr: 1'b0};
      mon_en = 1'b1;
    end else if (flush) begin
      exp_q.delete();
      last_r.mis  = 1'b0;
      last_r.rng  = 1'b0;
      last_r.perr = 1'b0;
    end else begin
      if (exp_q.size() != 0 && resp_ready) void'(exp_q.pop_front());
      if (req_valid && rdy) begin
        widx   = req_addr / 4;
        r.pc   = req_addr;
        r.mis  = (req_addr % 4) != 0;
        r.rng  = widx >= DEPTH;
        r.data = (r.mis || r.rng) ? NOP : mdl_mem[widx];
        r.perr = (r.mis || r.rng) ? 1'b0 : mdl_bad[widx];
        exp_q.push_back(r);
        last_r = r;
      end
    end
    // The load lands after the read above (old word on a collision).
    if (ld_en && ld_be != 4'd0) begin
      for (int i = 0; i < 4; i++)
        if (ld_be[i]) mdl_mem[ld_addr][8*i +: 8] = ld_data[8*i +: 8];
      mdl_bad[ld_addr] = ld_parity_flip;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: samples the outputs on the falling edge
  always @(negedge clk) begin
    resp_t e;
    logic  pend;
    if (mon_en) begin
      pend = exp_q.size() != 0;
      e    = pend ? exp_q[0] : last_r;
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, pend});
      chk("req_ready", {31'd0, req_ready},
          {31'd0, !rst && !flush && (!pend || resp_ready)});
      chk("resp_data", resp_data, e.data);
      chk("resp_pc", resp_pc, e.pc);
      chk("fault_misalign", {31'd0, resp_fault_misalign}, {31'd0, e.mis});
      chk("fault_range", {31'd0, resp_fault_range}, {31'd0, e.rng});
      chk("parity_err", {31'd0, resp_parity_err}, {31'd0, e.perr});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1; flush = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_be = 4'h0; ld_parity_flip = 1'b0;
  endtask

  task automatic load(input int idx, input logic [31:0] d, input logic [3:0] be,
                      input logic flip);
    ld_en = 1'b1; ld_addr = IW'(idx); ld_data = d; ld_be = be;
`ifdef IMEM_PARITY_EN
    ld_parity_flip = flip;
`else
    ld_parity_flip = 1'b0 & flip;
`endif
    tick();
    ld_en = 1'b0; ld_be = 4'h0; ld_parity_flip = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic rr);
    req_valid = 1'b1; req_addr = a; resp_ready = rr;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] prog [4];
    int          sel;
    prog[0] = 32'h0010_0093; prog[1] = 32'h0020_0113;
    prog[2] = 32'h0020_81B3; prog[3] = 32'h4020_8233;
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // program load, then back-to-back fetches
    for (int i = 0; i < 4; i++) load(i, prog[i], 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) fetch(32'(4 * i), 1'b1);
    tick();

    // stall for three cycles with a second request waiting
    fetch(32'h4, 1'b1);
    req_valid = 1'b1; req_addr = 32'h8; resp_ready = 1'b0;
    tick(); tick(); tick();
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();

    // faults, including the top word and the first word past the end
    fetch(32'h2, 1'b1);
    fetch(32'h400, 1'b1);
    fetch(32'((DEPTH - 1) * 4), 1'b1);
    fetch(32'h3FF, 1'b1);
    tick();

    // read/write collision on word 5
    load(5, 32'hAABB_CCDD, 4'hF, 1'b0);
    req_valid = 1'b1; req_addr = 32'h14;
    ld_en = 1'b1; ld_addr = 8'd5; ld_be = 4'b0010; ld_data = 32'h0000_1100;
    tick();
    ld_en = 1'b0; ld_be = 4'h0;
    fetch(32'h14, 1'b1);
    load(6, 32'h1234_5678, 4'h0, 1'b0);  // no byte enables: no write
    fetch(32'h18, 1'b1);
    tick();

    // flush of a stalled response while a request is waiting
    fetch(32'h2, 1'b0);
    req_valid = 1'b1; req_addr = 32'hC; flush = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    tick();

    // reset while stalled; memory must survive
    fetch(32'h0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; resp_ready = 1'b1;
    fetch(32'h14, 1'b1);
    fetch(32'hC, 1'b1);
    tick();

`ifdef IMEM_PARITY_EN
    load(7, 32'hCAFE_F00D, 4'hF, 1'b1);
    fetch(32'h1C, 1'b1);
    load(7, 32'hCAFE_F00D, 4'hF, 1'b0);
    fetch(32'h1C, 1'b1);
    tick();
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      req_valid  = $urandom_range(0, 3) != 0;
      resp_ready = $urandom_range(0, 3) != 0;
      flush      = $urandom_range(0, 19) == 0;
      rst        = $urandom_range(0, 199) == 0;
      sel        = $urandom_range(0, 9);
      if (sel < 7)       req_addr = 32'($urandom_range(0, 15)) << 2;
      else if (sel == 7) req_addr = 32'($urandom_range(0, 63)) | 32'h1;
      else if (sel == 8) req_addr = $urandom | 32'h400;
      else               req_addr = ($urandom_range(0, 1) != 0) ? 32'h3FC : 32'h400;
      ld_en   = $urandom_range(0, 3) == 0;
      ld_addr = IW'($urandom_range(0, 15));
      ld_data = $urandom;
      ld_be   = 4'($urandom_range(0, 15));
`ifdef IMEM_PARITY_EN
      ld_parity_flip = $urandom_range(0, 3) == 0;
`endif
      tick();
    end
    idle();
    rst = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_sync.md
Name: imem_sync

Overview:
Parametrised, clocked instruction memory for the fetch stage. It replaces the combinational lookup with a one-cycle registered read behind a valid/ready request/response handshake. It adds a byte-enabled program-load write port, a flush input, and misaligned/out-of-range fault reporting. It sits between the PC/fetch unit and the decode pipeline register.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, minimum 4.
ADDR_W, 32, width of the fetch address (byte address).
NOP_WORD, 32'h00000013, word returned on faults and used for memory initialisation and reset value of resp_data.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  fetch request present.
req_addr  in  ADDR_W  fetch byte address.
req_ready  out  1  request accepted when req_valid && req_ready.
resp_valid  out  1  response register holds a valid fetch.
resp_ready  in  1  consumer takes the response when resp_valid && resp_ready.
resp_data  out  32  fetched instruction.
resp_pc  out  ADDR_W  address of the fetch in resp_data.
resp_fault_misalign  out  1  req_addr[1:0] != 0.
resp_fault_range  out  1  word index >= DEPTH_WORDS.
flush  in  1  discard the pending response (redirect).
ld_en  in  1  program-load write strobe.
ld_addr  in  $clog2(DEPTH_WORDS)  word index for the load.
ld_data  in  32  load data.
ld_be  in  4  byte enables; bit i writes ld_data[8i+7:8i].

Behaviour:
- Memory initialised to NOP_WORD in every word at time zero. rst does NOT clear memory contents.
- Reset (rst=1 at edge):
  - resp_valid=0, resp_data=NOP_WORD, resp_pc=0, both fault flags=0.
  - req_ready is 0 while rst is high.
  - A load (ld_en) in a reset cycle is still performed.
- req_ready = !rst && !flush && (!resp_valid || resp_ready). Combinational; one outstanding response max.
- Accept (req_valid && req_ready) at edge N. At edge N the response register loads:
  - resp_valid=1, resp_pc=req_addr.
  - resp_data=mem[req_addr[$clog2(DEPTH_WORDS)+1:2]], or NOP_WORD if any fault.
  - resp_fault_misalign=(req_addr[1:0]!=0).
  - resp_fault_range=(req_addr[ADDR_W-1:2] >= DEPTH_WORDS).
  - Latency: request cycle to resp_valid is exactly 1 cycle.
- Back-to-back accepts: full throughput (one per cycle) while resp_ready=1.
- Stall: resp_valid && !resp_ready -> all resp_* outputs held bit-stable; req_ready=0.
- Consume without new request: resp_valid && resp_ready && !(req_valid && req_ready) -> resp_valid=0 next cycle; resp_data/pc/faults hold their last values.
- Flush priority:
  - flush=1 -> resp_valid=0 next cycle regardless of resp_ready.
  - No request is accepted in that cycle (req_ready=0).
  - Fault flags cleared.
- Load port: on edge with ld_en=1, bytes with ld_be[i]=1 are written; ld_be=0 is a no-op.
- Read/write collision (accept and load to the same word in the same cycle): the response returns the OLD word (read-before-write). The next fetch sees the new data.
- Reset mid-stall: the response is discarded (resp_valid=0) and the request is not re-issued.

Optional Feature:
Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed over the final merged 32-bit word on every load.
  - Initial parity matches NOP_WORD.
  - Extra output resp_parity_err (1 bit), registered with the response: 1 when the stored parity mismatches the read word, and the fetch is not already faulted.
  - resp_data still returns the raw word. resp_parity_err resets to 0, is held on stall, and is cleared on flush.
  - Extra input ld_parity_flip (1 bit): when 1 during a load, the stored parity is inverted (error injection).
- Not defined: no parity storage; resp_parity_err and ld_parity_flip ports do not exist.

Test Plan:
- Load words 0..3 = 0x00100093, 0x00200113, 0x002081B3, 0x40208233 (ld_be=4'hF); fetch 0x0, 0x4, 0x8, 0xC back-to-back with resp_ready=1 -> resp_valid each cycle from cycle+1, resp_data in order, resp_pc 0,4,8,C, no faults.
- Fetch 0x4 with resp_ready=0 for 3 cycles -> resp_data=0x00200113 and resp_pc=0x4 held stable, req_ready=0; on resp_ready=1 -> next request accepted same cycle.
- Fetch 0x2 -> resp_fault_misalign=1, resp_data=0x00000013. Fetch 0x400 with DEPTH_WORDS=256 -> resp_fault_range=1, resp_data=0x00000013.
- Word 5 = 0xAABBCCDD, then load ld_addr=5, ld_be=4'b0010, ld_data=0x00001100 in the same cycle as a fetch of 0x14 -> response 0xAABBCCDD; the next fetch of 0x14 -> 0xAABB11DD.
- Pending response stalled, flush=1 with req_valid=1 -> next cycle resp_valid=0, no accept in the flush cycle. rst mid-stall -> resp_valid=0, resp_data=0x00000013, memory contents preserved.
- IMEM_PARITY_EN: load word 7 with ld_parity_flip=1, fetch 0x1C -> resp_parity_err=1; reload it without flip, fetch again -> 0.
